cla13_share_arbiter: RTL and testbench

Round-robin arbiter and two-stage sequencer that shares one `carry_lookahead_adder_13bit` instance among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and registers the winning pair into an operand stage that drives the shared adder. It then captures the 14-bit sum with the requester ID into a result stage that drains through a valid/ready response port. The block sits between requester front-ends and the adder instance; the adder itself stays outside the block.

---
 rtl/cla13_share_arbiter.sv | 125 ++++++++++++
 tb/tb_cla13_share_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cla13_share_arbiter.sv
// Round-robin front end that time-shares one external 13-bit carry-lookahead adder.
// Two registered stages: the operand stage drives the adder and the result stage holds its sum.
module cla13_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*13-1:0]   i_req_a,
  input  logic [NREQ*13-1:0]   i_req_b,
  output logic [12:0]          o_add1,
  output logic [12:0]          o_add2,
  input  logic [13:0]          i_sum,
  output logic                 o_rsp_valid,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [13:0]          o_rsp_result,
  input  logic                 i_rsp_ready
);

  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  logic             op_v_r;
  logic [IDW-1:0]   op_id_r;
  logic [12:0]      add1_r;
  logic [12:0]      add2_r;
  logic             rs_v_r;
  logic [IDW-1:0]   rs_id_r;
  logic [13:0]      rs_result_r;
  logic [IDW-1:0]   rr_ptr_r;

  logic             rs_free_s;
  logic             op_adv_s;
  logic             op_free_s;
  logic [NREQ-1:0]  grant_s;
  logic             gnt_any_s;
  logic [IDW-1:0]   gnt_id_s;
  logic [IDW:0]     cand_s;
  logic [IDW:0]     cand_raw_s;
  logic             hit_s;
  logic [12:0]      sel_a_s;
  logic [12:0]      sel_b_s;
  logic [IDW-1:0]   ptr_nxt_s;

  assign rs_free_s = ~rs_v_r | i_rsp_ready;
  assign op_adv_s  = op_v_r & rs_free_s;
  assign op_free_s = ~op_v_r | op_adv_s;

  // Round-robin search upward from rr_ptr; the first valid requester wins.
  always_comb begin
    grant_s    = '0;
    gnt_any_s  = 1'b0;
    gnt_id_s   = '0;
    cand_s     = '0;
    cand_raw_s = '0;
    hit_s      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand_raw_s = {1'b0, rr_ptr_r} + (IDW+1)'(i);
      cand_s     = (cand_raw_s >= NREQ_W) ? (cand_raw_s - NREQ_W) : cand_raw_s;
      for (int j = 0; j < NREQ; j++) begin
        hit_s      = ~gnt_any_s & i_rst_n & op_free_s & i_req_valid[j] &
                     (cand_s == (IDW+1)'(j));
        grant_s[j] = grant_s[j] | hit_s;
        gnt_id_s   = hit_s ? IDW'(j) : gnt_id_s;
        gnt_any_s  = gnt_any_s | hit_s;
      end
    end
  end

  // Operand select for the granted requester (only the one-hot bit contributes).
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int j = 0; j < NREQ; j++) begin
      sel_a_s = grant_s[j] ? i_req_a[13*j +: 13] : sel_a_s;
      sel_b_s = grant_s[j] ? i_req_b[13*j +: 13] : sel_b_s;
    end
  end

  assign ptr_nxt_s = (gnt_id_s == LAST_ID) ? '0 : (gnt_id_s + IDW'(1));

  // Operand stage and round-robin pointer; operands keep their value when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_v_r   <= 1'b0;
      op_id_r  <= '0;
      add1_r   <= 13'd0;
      add2_r   <= 13'd0;
      rr_ptr_r <= '0;
    end else if (gnt_any_s) begin
      op_v_r   <= 1'b1;
      op_id_r  <= gnt_id_s;
      add1_r   <= sel_a_s;
      add2_r   <= sel_b_s;
      rr_ptr_r <= ptr_nxt_s;
    end else if (op_adv_s) begin
      op_v_r   <= 1'b0;
    end
  end

  // Result stage: captures the adder output as the operand stage advances.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rs_v_r      <= 1'b0;
      rs_id_r     <= '0;
      rs_result_r <= 14'd0;
    end else if (op_adv_s) begin
      rs_v_r      <= 1'b1;
      rs_id_r     <= op_id_r;
      rs_result_r <= i_sum;
    end else if (i_rsp_ready) begin
      rs_v_r      <= 1'b0;
    end
  end

  assign o_req_ready  = grant_s;
  assign o_add1       = add1_r;
  assign o_add2       = add2_r;
  assign o_rsp_valid  = rs_v_r;
  assign o_rsp_id     = rs_id_r;
  assign o_rsp_result = rs_result_r;

endmodule

// File: tb/tb_cla13_share_arbiter.sv
// Directed bench for cla13_share_arbiter: expected responses are queued at grant time
// and a negedge monitor compares every accepted response in order.
module tb_cla13_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i_req_valid;
  logic [3:0]  o_req_ready;
  logic [51:0] i_req_a;
  logic [51:0] i_req_b;
  logic [12:0] o_add1;
  logic [12:0] o_add2;
  logic [13:0] i_sum;
  logic        o_rsp_valid;
  logic [1:0]  o_rsp_id;
  logic [13:0] o_rsp_result;
  logic        i_rsp_ready;

  int          total;
  int          bad;
  logic [15:0] exp_q[$];
  logic [13:0] exp_sum[4];
  logic [15:0] mon_e;

  cla13_share_arbiter #(.NREQ(4), .IDW(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_a      (i_req_a),
    .i_req_b      (i_req_b),
    .o_add1       (o_add1),
    .o_add2       (o_add2),
    .i_sum        (i_sum),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_result (o_rsp_result),
    .i_rsp_ready  (i_rsp_ready)
  );

  // external adder model
  assign i_sum = {1'b0, o_add1} + {1'b0, o_add2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_op(input int r, input logic [12:0] a, input logic [12:0] b,
                        input logic [13:0] s);
    i_req_a[13*r +: 13] = a;
    i_req_b[13*r +: 13] = b;
    exp_sum[r] = s;
  endtask

  // one clock: drive inputs, check grant at negedge, queue expected response
  task automatic grant_step(input logic [3:0] vld, input logic rdy,
                            input logic [3:0] exp_g, input string nm);
    i_req_valid = vld;
    i_rsp_ready = rdy;
    @(negedge clk);
    chk(nm, 32'(o_req_ready), 32'(exp_g));
    for (int j = 0; j < 4; j++) begin
      if (exp_g[j]) exp_q.push_back({2'(j), exp_sum[j]});
    end
    @(posedge clk);
    #1;
  endtask

  // response monitor
  always @(negedge clk) begin
    if (rst_n && o_rsp_valid && i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d result=0x%0h expected no response",
                 o_rsp_id, o_rsp_result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 32'(o_rsp_id), 32'(mon_e[15:14]));
        chk("rsp_result", 32'(o_rsp_result), 32'(mon_e[13:0]));
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    i_req_valid = 4'd0;
    i_rsp_ready = 1'b0;
    i_req_a = 52'd0;
    i_req_b = 52'd0;
    for (int r = 0; r < 4; r++) exp_sum[r] = 14'd0;

    #3;
    chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset_ready", 32'(o_req_ready), 32'd0);
    chk("reset_add1", 32'(o_add1), 32'd0);
    chk("reset_result", 32'(o_rsp_result), 32'd0);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single request with carry across bit 12
    set_op(1, 13'h1FFF, 13'h0001, 14'h2000);
    grant_step(4'b0010, 1'b1, 4'b0010, "single_grant");
    i_req_valid = 4'b0000;
    @(negedge clk);
    chk("single_ready_low", 32'(o_req_ready), 32'd0);
    chk("single_op_add1", 32'(o_add1), 32'h1FFF);
    chk("single_not_yet_valid", 32'(o_rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single_rsp_valid", 32'(o_rsp_valid), 32'd1);
    @(posedge clk);
    #1;

    // all requesting, pointer starts at 2
    set_op(0, 13'h0123, 13'h0456, 14'h0579);
    set_op(1, 13'h1000, 13'h1000, 14'h2000);
    set_op(2, 13'h0ABC, 13'h1111, 14'h1BCD);
    set_op(3, 13'h1FFF, 13'h1FFF, 14'h3FFE);
    for (int k = 0; k < 2; k++) begin
      grant_step(4'b1111, 1'b1, 4'b0100, "rr_all_g2");
      grant_step(4'b1111, 1'b1, 4'b1000, "rr_all_g3");
      grant_step(4'b1111, 1'b1, 4'b0001, "rr_all_g0");
      grant_step(4'b1111, 1'b1, 4'b0010, "rr_all_g1");
    end
    grant_step(4'b0000, 1'b1, 4'b0000, "idle");
    grant_step(4'b0000, 1'b1, 4'b0000, "idle");

    // backpressure: r0 r1 r3 requesting, consumer stalled
    set_op(0, 13'h0000, 13'h0000, 14'h0000);
    set_op(1, 13'h0FFF, 13'h0001, 14'h1000);
    grant_step(4'b1011, 1'b0, 4'b1000, "bp_grant_r3");
    grant_step(4'b0011, 1'b0, 4'b0001, "bp_grant_r0");
    for (int k = 0; k < 5; k++) begin
      grant_step(4'b0010, 1'b0, 4'b0000, "bp_stalled");
      chk("bp_hold_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(o_rsp_id), 32'd3);
      chk("bp_hold_result", 32'(o_rsp_result), 32'h3FFE);
    end
    grant_step(4'b0010, 1'b1, 4'b0010, "bp_resume_r1");
    grant_step(4'b0000, 1'b1, 4'b0000, "idle");
    grant_step(4'b0000, 1'b1, 4'b0000, "idle");

    // wrap and skip: move pointer to 3, then only r0 and r2
    set_op(2, 13'h0001, 13'h0002, 14'h0003);
    set_op(0, 13'h0010, 13'h0020, 14'h0030);
    grant_step(4'b0100, 1'b1, 4'b0100, "wrap_set_ptr");
    grant_step(4'b0101, 1'b1, 4'b0001, "wrap_r0");
    grant_step(4'b0101, 1'b1, 4'b0100, "skip_r2");
    grant_step(4'b0101, 1'b1, 4'b0001, "wrap_r0_again");
    grant_step(4'b0000, 1'b1, 4'b0000, "idle");
    grant_step(4'b0000, 1'b1, 4'b0000, "idle");

    // reset with both stages full
    set_op(1, 13'h0555, 13'h0AAA, 14'h0FFF);
    grant_step(4'b0110, 1'b0, 4'b0010, "fill_r1");
    grant_step(4'b0100, 1'b0, 4'b0100, "fill_r2");
    grant_step(4'b1100, 1'b0, 4'b0000, "full_stall");
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("async_rst_id", 32'(o_rsp_id), 32'd0);
    chk("async_rst_result", 32'(o_rsp_result), 32'd0);
    chk("async_rst_add1", 32'(o_add1), 32'd0);
    chk("async_rst_add2", 32'(o_add2), 32'd0);
    chk("async_rst_ready", 32'(o_req_ready), 32'd0);
    set_op(2, 13'h0100, 13'h0200, 14'h0300);
    set_op(3, 13'h1FFF, 13'h1FFF, 14'h3FFE);
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #3;
    chk("in_rst_ready", 32'(o_req_ready), 32'd0);
    rst_n = 1'b1;
    grant_step(4'b1100, 1'b1, 4'b0100, "post_rst_lowest");
    grant_step(4'b1000, 1'b1, 4'b1000, "post_rst_r3");
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() != 0) grant_step(4'b0000, 1'b1, 4'b0000, "drain");
    end
    grant_step(4'b0000, 1'b1, 4'b0000, "final_idle");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_rsp_valid", 32'(o_rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
